// File: rtl/vga_register_display.sv
// 640x480@60 VGA text renderer: shows 11 snapshotted 16-bit registers as hex rows.
// Two pixel-tick pipeline stages keep colour and sync aligned at the connector.
module vga_register_display #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned X0      = 32,
  parameter int unsigned Y0      = 32,
  parameter logic [8:0]  FG      = 9'h1FF,
  parameter logic [8:0]  BG      = 9'h000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [175:0] registers,
  output logic         vgaHs,
  output logic         vgaVs,
  output logic [2:0]   vgaR,
  output logic [2:0]   vgaG,
  output logic [2:0]   vgaB,
  output logic         frameStart
);

  localparam int unsigned DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL     = 800;
  localparam int unsigned H_VIS       = 640;
  localparam int unsigned H_SYNC_BEG  = 656;
  localparam int unsigned H_SYNC_END  = 752;
  localparam int unsigned V_TOTAL     = 525;
  localparam int unsigned V_VIS       = 480;
  localparam int unsigned V_SYNC_BEG  = 490;
  localparam int unsigned V_SYNC_END  = 492;
  localparam int unsigned TEXT_W      = 64;
  localparam int unsigned TEXT_H      = 176;
  localparam int unsigned REG_BITS    = 176;
  localparam int unsigned PAD_BITS    = 256;
  localparam logic signed [10:0] TEXT_W_S = 11'(TEXT_W);
  localparam logic signed [10:0] TEXT_H_S = 11'(TEXT_H);

  logic [DIV_W-1:0] divCnt;
  logic             pixEn;
  logic [9:0]       hCnt;
  logic [9:0]       vCnt;
  logic             hWrap;
  logic [9:0]       vNext;
  logic             snapTick;
  logic [REG_BITS-1:0] shadow;

  assign pixEn    = (divCnt == DIV_W'(CLK_DIV - 1));
  assign hWrap    = (hCnt == 10'(H_TOTAL - 1));
  assign snapTick = pixEn && (hCnt == 10'd0) && (vCnt == 10'(V_VIS));

  always_comb begin
    vNext = vCnt;
    if (hWrap) vNext = (vCnt == 10'(V_TOTAL - 1)) ? 10'd0 : vCnt + 10'd1;
  end

  // Pixel clock enable.
  always_ff @(posedge clk) begin
    if (rst)        divCnt <= '0;
    else if (pixEn) divCnt <= '0;
    else            divCnt <= divCnt + DIV_W'(1);
  end

  // Raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (pixEn) begin
      hCnt <= hWrap ? 10'd0 : hCnt + 10'd1;
      vCnt <= vNext;
    end
  end

  // Frame snapshot taken at the start of vertical blanking so rows never tear.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      frameStart <= 1'b0;
    end else begin
      frameStart <= snapTick;
      if (snapTick) shadow <= registers;
    end
  end

  logic signed [10:0] rx;
  logic signed [10:0] ry;
  logic               inBlock;
  logic [PAD_BITS-1:0] shadowPad;
  logic [15:0]        word;
  logic [3:0]         nib;

  assign rx        = 11'(hCnt) - 11'(X0);
  assign ry        = 11'(vCnt) - 11'(Y0);
  assign inBlock   = (rx >= 11'sd0) && (rx < TEXT_W_S) && (ry >= 11'sd0) && (ry < TEXT_H_S);
  assign shadowPad = {(PAD_BITS - REG_BITS)'(0), shadow};
  assign word      = shadowPad[{ry[7:4], 4'b0000} +: 16];
  assign nib       = word[{~rx[5:4], 2'b00} +: 4];

  logic       s1InBlock;
  logic [3:0] s1Nib;
  logic [2:0] s1Gx;
  logic [2:0] s1Gy;
  logic       s1Vis;
  logic       s1Hs;
  logic       s1Vs;

  // Stage 1: position decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1InBlock <= 1'b0;
      s1Nib     <= '0;
      s1Gx      <= '0;
      s1Gy      <= '0;
      s1Vis     <= 1'b0;
      s1Hs      <= 1'b1;
      s1Vs      <= 1'b1;
    end else if (pixEn) begin
      s1InBlock <= inBlock;
      s1Nib     <= nib;
      s1Gx      <= rx[3:1];
      s1Gy      <= ry[3:1];
      s1Vis     <= (hCnt < 10'(H_VIS)) && (vCnt < 10'(V_VIS));
      s1Hs      <= !((hCnt >= 10'(H_SYNC_BEG)) && (hCnt < 10'(H_SYNC_END)));
      s1Vs      <= !((vCnt >= 10'(V_SYNC_BEG)) && (vCnt < 10'(V_SYNC_END)));
    end
  end

  // Hex font: row 0 in the top byte, bit 7 is the leftmost pixel.
  function automatic logic [63:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 64'h3C666E7666663C00;
      4'h1: glyph = 64'h1838181818187E00;
      4'h2: glyph = 64'h3C66060C18307E00;
      4'h3: glyph = 64'h3C66061C06663C00;
      4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
      4'h5: glyph = 64'h7E607C0606663C00;
      4'h6: glyph = 64'h3C607C6666663C00;
      4'h7: glyph = 64'h7E060C1830303000;
      4'h8: glyph = 64'h3C66663C66663C00;
      4'h9: glyph = 64'h3C66663E060C3800;
      4'hA: glyph = 64'h183C66667E666600;
      4'hB: glyph = 64'h7C66667C66667C00;
      4'hC: glyph = 64'h3C66606060663C00;
      4'hD: glyph = 64'h786C6666666C7800;
      4'hE: glyph = 64'h7E60607C60607E00;
      default: glyph = 64'h7E60607C60606000;
    endcase
  endfunction

  logic [63:0] glyphBits;
  logic [7:0]  fontRow;
  logic        fontBit;

  assign glyphBits = glyph(s1Nib);
  assign fontRow   = glyphBits[{~s1Gy, 3'b000} +: 8];
  assign fontBit   = fontRow[~s1Gx];

  // Stage 2: colour and sync outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      {vgaR, vgaG, vgaB} <= 9'h000;
      vgaHs              <= 1'b1;
      vgaVs              <= 1'b1;
    end else if (pixEn) begin
      {vgaR, vgaG, vgaB} <= (s1Vis && s1InBlock) ? (fontBit ? FG : BG) : 9'h000;
      vgaHs              <= s1Hs;
      vgaVs              <= s1Vs;
    end
  end

endmodule

// File: tb/tb_vga_register_display.sv
// Bench for vga_register_display: raster model, pixel scoreboard and sync timing checks.
// Vertical position is fast-forwarded by briefly forcing the line counter mid-line.
module tb_vga_register_display;

  logic         clk = 1'b0;
  logic         rst;
  logic [175:0] registers;
  logic         vgaHs, vgaVs, frameStart;
  logic [2:0]   vgaR, vgaG, vgaB;
  logic [8:0]   rgb;

  vga_register_display dut (
    .clk(clk), .rst(rst), .registers(registers),
    .vgaHs(vgaHs), .vgaVs(vgaVs),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
    .frameStart(frameStart)
  );

  always #5 clk = ~clk;
  assign rgb = {vgaR, vgaG, vgaB};

  typedef struct {
    int         h;
    int         v;
    logic [8:0] rgb;
    string      tag;
  } pix_t;

  pix_t q[$];
  int total = 0;
  int bad   = 0;

  // Independent raster model: current position plus the two-tick output history.
  int mdiv, mh, mv, p1h, p1v, ph, pv, nTicks, curV;
  bit fsExp;
  bit jumpReq = 1'b0;
  int jumpV   = 0;
  logic [9:0] jumpV10;

  always_comb curV = jumpReq ? jumpV : mv;

  always @(posedge clk) begin
    if (rst) begin
      mdiv <= 0; mh <= 0; mv <= 0; p1h <= 0; p1v <= 0; ph <= 0; pv <= 0;
      nTicks <= 0; fsExp <= 1'b0;
    end else begin
      fsExp <= 1'b0;
      if (mdiv == 1) begin
        mdiv   <= 0;
        fsExp  <= (mh == 0) && (curV == 480);
        p1h    <= mh;  p1v <= curV;
        ph     <= p1h; pv  <= p1v;
        nTicks <= (nTicks < 2) ? nTicks + 1 : nTicks;
        mh     <= (mh == 799) ? 0 : mh + 1;
        mv     <= (mh == 799) ? ((curV == 524) ? 0 : curV + 1) : curV;
      end else begin
        mdiv <= mdiv + 1;
      end
    end
  end

  function automatic bit inBlock(input int h, input int v);
    return (h >= 32) && (h < 96) && (v >= 32) && (v < 208);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Continuous sync/blanking/frameStart checks and scoreboard pops.
  task automatic monitor();
    pix_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("frameStart", 32'(frameStart), 32'(fsExp));
        if (nTicks >= 2) begin
          chk("hsync", 32'(vgaHs), 32'(!((ph >= 656) && (ph < 752))));
          chk("vsync", 32'(vgaVs), 32'(!((pv >= 490) && (pv < 492))));
          if (!inBlock(ph, pv)) chk("blank", 32'(rgb), 32'h0);
          if (q.size() > 0 && q[0].h == ph && q[0].v == pv) begin
            e = q.pop_front();
            chk(e.tag, 32'(rgb), 32'(e.rgb));
          end
        end
      end
    end
  endtask

  task automatic expectPix(input int h, input int v, input logic [8:0] c, input string tag);
    pix_t e;
    e.h = h; e.v = v; e.rgb = c; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("drainTimeout", 32'(q.size()), 32'h0);
      q.delete();
    end
  endtask

  // Jump so that the next line scanned is v (counter set to v-1 mid-line).
  task automatic gotoLine(input int v);
    int n = 0;
    while (mh != 400 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (mh != 400) chk("gotoTimeout", 32'(mh), 32'd400);
    jumpV   = (v == 0) ? 524 : v - 1;
    jumpV10 = 10'(jumpV);
    force dut.vCnt = jumpV10;
    jumpReq = 1'b1;
    @(negedge clk);
    @(negedge clk);
    release dut.vCnt;
    jumpReq = 1'b0;
  endtask

  localparam logic [8:0] FGC = 9'h1FF;
  localparam logic [8:0] BGC = 9'h000;

  initial begin
    int n, lowN;
    rst = 1'b1;
    registers = '0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rstHs", 32'(vgaHs), 32'h1);
    chk("rstVs", 32'(vgaVs), 32'h1);
    chk("rstRgb", 32'(rgb), 32'h0);
    chk("rstFs", 32'(frameStart), 32'h0);
    @(negedge clk) rst = 1'b0;

    n = 0;
    do begin @(posedge clk); #1; n++; end while (vgaHs !== 1'b0 && n < 3000);
    chk("hsFirstFall", 32'(n), 32'd1316);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (vgaHs !== 1'b1 && n < 3000);
    chk("hsLowWidth", 32'(n), 32'd192);
    lowN = n; n = 0;
    do begin @(posedge clk); #1; n++; end while (vgaHs !== 1'b0 && n < 3000);
    chk("hsPeriod", 32'(lowN + n), 32'd1600);

    // Shadow is zero after reset: row 0 shows '0' (row0 = 3C).
    gotoLine(32);
    expectPix(32, 32, BGC, "r0gx0zero");
    expectPix(36, 32, FGC, "r0gx2zero");
    expectPix(84, 32, FGC, "r0c3gx2zero");
    drain();

    // Mid-frame update must stay invisible until the next snapshot.
    gotoLine(100);
    registers[15:0]    = 16'h1234;
    registers[175:160] = 16'hF000;
    gotoLine(192);
    expectPix(34, 192, BGC, "noTearGx1");
    expectPix(36, 192, FGC, "noTearGx2");
    drain();

    gotoLine(480);
    n = 0;
    while (frameStart !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    chk("fsSeen", 32'(frameStart), 32'h1);
    chk("fsPosH", 32'(mh), 32'd1);
    chk("fsPosV", 32'(mv), 32'd480);

    gotoLine(490);
    n = 0;
    while (vgaVs !== 1'b0 && n < 5000) begin @(posedge clk); #1; n++; end
    chk("vsFall", 32'(vgaVs), 32'h0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (vgaVs !== 1'b1 && n < 5000);
    chk("vsLowWidth", 32'(n), 32'd3200);

    // Next frame shows 1234 in row 0 and F000 in row 10.
    gotoLine(0);
    gotoLine(32);
    expectPix(36, 32, BGC, "dig1gx2");
    expectPix(38, 32, FGC, "dig1gx3");
    expectPix(52, 32, FGC, "dig2gx2");
    expectPix(68, 32, FGC, "dig3gx2");
    expectPix(84, 32, BGC, "dig4gx2");
    expectPix(88, 32, FGC, "dig4gx4");
    drain();
    gotoLine(112);
    expectPix(36, 112, FGC, "row5zero");
    drain();
    gotoLine(192);
    expectPix(31, 192, BGC, "leftOfBlock");
    expectPix(32, 192, BGC, "r10FGx0");
    expectPix(34, 192, FGC, "r10FGx1");
    expectPix(52, 192, FGC, "r10c1zero");
    expectPix(96, 192, 9'h000, "rightOfBlock");
    drain();
    gotoLine(194);
    expectPix(34, 194, FGC, "r10Fy1gx1");
    expectPix(44, 194, BGC, "r10Fy1gx6");
    drain();
    gotoLine(208);
    expectPix(36, 208, 9'h000, "belowBlock");
    drain();

    // Mid-frame reset restarts timing and clears the shadow.
    gotoLine(300);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midRstHs", 32'(vgaHs), 32'h1);
    chk("midRstRgb", 32'(rgb), 32'h0);
    @(negedge clk) rst = 1'b0;
    gotoLine(32);
    expectPix(36, 32, FGC, "postRstR0gx2");
    expectPix(38, 32, FGC, "postRstR0gx3");
    drain();
    gotoLine(192);
    expectPix(34, 192, BGC, "postRstR10gx1");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
